eth_wb_slave_regs: RTL and testbench

Wishbone classic-cycle responder for the 10GE MAC management port. It answers the transfers driven on wb_adr_i/wb_dat_i/wb_we_i/wb_stb_i/wb_cyc_i and holds the MAC configuration, version and interrupt registers. It drives wb_dat_o/wb_ack_o/wb_int_o back to the Wishbone master and exposes configuration bits and interrupt-event inputs to the MAC datapath.

---
 rtl/eth_wb_pkg.sv | 23 ++
 rtl/eth_wb_int_ctrl.sv | 47 ++++
 rtl/eth_wb_slave_regs.sv | 98 +++++++++
 tb/tb_eth_wb_slave_regs.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/eth_wb_pkg.sv
// Shared constants and types for the 10GE MAC Wishbone management register block.
package eth_wb_pkg;

  localparam int unsigned WB_ADR_W  = 8;
  localparam int unsigned WB_DAT_W  = 32;
  localparam int unsigned WB_WORD_W = WB_ADR_W - 2;
  localparam int unsigned CFG_W     = 3;

  // Word indices, i.e. byte address >> 2
  localparam logic [WB_WORD_W-1:0] ADDR_CONFIG      = 6'h00;
  localparam logic [WB_WORD_W-1:0] ADDR_VERSION     = 6'h01;
  localparam logic [WB_WORD_W-1:0] ADDR_INT_PENDING = 6'h02;
  localparam logic [WB_WORD_W-1:0] ADDR_INT_MASK    = 6'h03;
  localparam logic [WB_WORD_W-1:0] ADDR_INT_STATUS  = 6'h04;

  localparam logic [CFG_W-1:0] CONFIG_RST = 3'b011;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } wb_state_e;

endpackage

// File: rtl/eth_wb_int_ctrl.sv
// Interrupt pending/mask registers with W1C clear, set-wins priority and a
// registered interrupt request.
module eth_wb_int_ctrl #(
  parameter int unsigned INT_WIDTH = 9
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [INT_WIDTH-1:0] int_event_i,
  input  logic                 pend_clr_we_i,
  input  logic                 mask_we_i,
  input  logic [INT_WIDTH-1:0] wdata_i,
  output logic [INT_WIDTH-1:0] pending_o,
  output logic [INT_WIDTH-1:0] mask_o,
  output logic                 int_o
);

  logic [INT_WIDTH-1:0] pend_q, pend_d;
  logic [INT_WIDTH-1:0] mask_q, mask_d;
  logic                 int_q, int_d;

  // Events are OR-ed in after the clear so a coincident event survives
  always_comb begin
    pend_d = pend_q;
    mask_d = mask_q;
    int_d  = |(pend_q & mask_q);
    if (pend_clr_we_i) pend_d = pend_q & ~wdata_i;
    pend_d = pend_d | int_event_i;
    if (mask_we_i) mask_d = wdata_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q <= '0;
      mask_q <= '0;
      int_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      mask_q <= mask_d;
      int_q  <= int_d;
    end
  end

  assign pending_o = pend_q;
  assign mask_o    = mask_q;
  assign int_o     = int_q;

endmodule

// File: rtl/eth_wb_slave_regs.sv
// Wishbone classic-cycle responder holding the 10GE MAC CONFIG, VERSION and
// interrupt registers.
module eth_wb_slave_regs
  import eth_wb_pkg::*;
#(
  parameter int unsigned INT_WIDTH = 9,
  parameter logic [31:0] VERSION   = 32'h0001_0000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WB_ADR_W-1:0]  wb_adr_i,
  input  logic [WB_DAT_W-1:0]  wb_dat_i,
  input  logic                 wb_we_i,
  input  logic                 wb_stb_i,
  input  logic                 wb_cyc_i,
  output logic                 wb_ack_o,
  output logic [WB_DAT_W-1:0]  wb_dat_o,
  output logic                 wb_int_o,
  input  logic [INT_WIDTH-1:0] int_event_i,
  output logic                 cfg_tx_enable_o,
  output logic                 cfg_rx_enable_o,
  output logic                 cfg_promisc_o
);

  wb_state_e             state_q, state_d;
  logic [WB_DAT_W-1:0]   dat_q, dat_d, rd_data;
  logic [CFG_W-1:0]      cfg_q, cfg_d;
  logic [WB_WORD_W-1:0]  word_adr;
  logic                  req, wr;
  logic                  cfg_we, pend_clr_we, mask_we;
  logic [INT_WIDTH-1:0]  pending, mask;
  logic                  unused_bits;

  assign word_adr    = wb_adr_i[WB_ADR_W-1:2];
  assign unused_bits = ^{wb_adr_i[1:0], wb_dat_i};

  // The ack state blocks a re-request, giving one transfer per two cycles
  assign req         = wb_cyc_i & wb_stb_i & (state_q == ST_IDLE);
  assign wr          = req & wb_we_i;
  assign cfg_we      = wr & (word_adr == ADDR_CONFIG);
  assign pend_clr_we = wr & (word_adr == ADDR_INT_PENDING);
  assign mask_we     = wr & (word_adr == ADDR_INT_MASK);

  always_comb begin
    rd_data = '0;
    case (word_adr)
      ADDR_CONFIG:      rd_data = WB_DAT_W'(cfg_q);
      ADDR_VERSION:     rd_data = VERSION;
      ADDR_INT_PENDING: rd_data = WB_DAT_W'(pending);
      ADDR_INT_MASK:    rd_data = WB_DAT_W'(mask);
      ADDR_INT_STATUS:  rd_data = WB_DAT_W'(pending & mask);
      default:          rd_data = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cfg_d   = cfg_q;
    dat_d   = '0;
    case (state_q)
      ST_IDLE: if (req) state_d = ST_ACK;
      ST_ACK:  state_d = ST_IDLE;
    endcase
    if (cfg_we) cfg_d = wb_dat_i[CFG_W-1:0];
    if (req && !wb_we_i) dat_d = rd_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      dat_q   <= '0;
      cfg_q   <= CONFIG_RST;
    end else begin
      state_q <= state_d;
      dat_q   <= dat_d;
      cfg_q   <= cfg_d;
    end
  end

  eth_wb_int_ctrl #(.INT_WIDTH(INT_WIDTH)) u_int_ctrl (
    .clk           (clk),
    .rst           (rst),
    .int_event_i   (int_event_i),
    .pend_clr_we_i (pend_clr_we),
    .mask_we_i     (mask_we),
    .wdata_i       (wb_dat_i[INT_WIDTH-1:0]),
    .pending_o     (pending),
    .mask_o        (mask),
    .int_o         (wb_int_o)
  );

  assign wb_ack_o        = (state_q == ST_ACK);
  assign wb_dat_o        = dat_q;
  assign cfg_tx_enable_o = cfg_q[0];
  assign cfg_rx_enable_o = cfg_q[1];
  assign cfg_promisc_o   = cfg_q[2];

endmodule

// File: tb/tb_eth_wb_slave_regs.sv
// Directed scoreboard bench for the MAC Wishbone register block.
module tb_eth_wb_slave_regs;

  localparam int unsigned INT_W = 9;

  logic             clk = 1'b0;
  logic             rst;
  logic [7:0]       wb_adr_i;
  logic [31:0]      wb_dat_i;
  logic             wb_we_i, wb_stb_i, wb_cyc_i;
  logic             wb_ack_o;
  logic [31:0]      wb_dat_o;
  logic             wb_int_o;
  logic [INT_W-1:0] int_event_i;
  logic             cfg_tx_enable_o, cfg_rx_enable_o, cfg_promisc_o;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] sb[$];

  eth_wb_slave_regs #(.INT_WIDTH(INT_W), .VERSION(32'h0001_0000)) dut (
    .clk             (clk),
    .rst             (rst),
    .wb_adr_i        (wb_adr_i),
    .wb_dat_i        (wb_dat_i),
    .wb_we_i         (wb_we_i),
    .wb_stb_i        (wb_stb_i),
    .wb_cyc_i        (wb_cyc_i),
    .wb_ack_o        (wb_ack_o),
    .wb_dat_o        (wb_dat_o),
    .wb_int_o        (wb_int_o),
    .int_event_i     (int_event_i),
    .cfg_tx_enable_o (cfg_tx_enable_o),
    .cfg_rx_enable_o (cfg_rx_enable_o),
    .cfg_promisc_o   (cfg_promisc_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk1({tag, " ack"}, wb_ack_o, 1'b0);
    chk({tag, " dat"}, wb_dat_o, 32'h0);
    chk1({tag, " int"}, wb_int_o, 1'b0);
    chk1({tag, " tx_en"}, cfg_tx_enable_o, 1'b1);
    chk1({tag, " rx_en"}, cfg_rx_enable_o, 1'b1);
    chk1({tag, " promisc"}, cfg_promisc_o, 1'b0);
  endtask

  // One single-beat transfer; returns at the negedge of the ack cycle
  task automatic xfer(input logic we, input logic [7:0] adr, input logic [31:0] dat,
                      input logic [31:0] exp, input logic [INT_W-1:0] ev, input string tag);
    logic [31:0] e;
    @(negedge clk);
    chk1({tag, " idle"}, wb_ack_o, 1'b0);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
    wb_adr_i = adr; wb_dat_i = dat; int_event_i = ev;
    if (!we) sb.push_back(exp);
    @(negedge clk);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0; int_event_i = '0;
    chk1({tag, " ack"}, wb_ack_o, 1'b1);
    if (!we) begin
      chk1({tag, " sb"}, sb.size() != 0, 1'b1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk({tag, " rdata"}, wb_dat_o, e);
      end
    end else begin
      chk({tag, " wdat0"}, wb_dat_o, 32'h0);
    end
  endtask

  task automatic pulse_event(input logic [INT_W-1:0] ev);
    @(negedge clk);
    int_event_i = ev;
    @(negedge clk);
    int_event_i = '0;
  endtask

  initial begin
    int          acks;
    logic [31:0] e;

    rst = 1'b1; wb_adr_i = '0; wb_dat_i = '0; wb_we_i = 1'b0;
    wb_stb_i = 1'b0; wb_cyc_i = 1'b0; int_event_i = '0;
    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b0;

    // Reset readback
    xfer(1'b0, 8'h00, 32'h0, 32'h0000_0003, '0, "rd CONFIG rst");
    xfer(1'b0, 8'h04, 32'h0, 32'h0001_0000, '0, "rd VERSION");
    xfer(1'b0, 8'h08, 32'h0, 32'h0,         '0, "rd PEND rst");
    xfer(1'b0, 8'h0C, 32'h0, 32'h0,         '0, "rd MASK rst");
    xfer(1'b0, 8'h10, 32'h0, 32'h0,         '0, "rd STATUS rst");

    // CONFIG write visible in ack cycle
    xfer(1'b1, 8'h00, 32'hFFFF_FFFC, 32'h0, '0, "wr CONFIG");
    chk1("cfg tx_en", cfg_tx_enable_o, 1'b0);
    chk1("cfg rx_en", cfg_rx_enable_o, 1'b0);
    chk1("cfg promisc", cfg_promisc_o, 1'b1);
    xfer(1'b0, 8'h00, 32'h0, 32'h0000_0004, '0, "rd CONFIG");

    // Mask, events, interrupt timing and W1C
    xfer(1'b1, 8'h0C, 32'h0000_0005, 32'h0, '0, "wr MASK");
    pulse_event(9'h101);
    chk1("int before rise", wb_int_o, 1'b0);
    @(negedge clk);
    chk1("int rise", wb_int_o, 1'b1);
    xfer(1'b0, 8'h08, 32'h0, 32'h0000_0101, '0, "rd PEND ev");
    xfer(1'b0, 8'h10, 32'h0, 32'h0000_0001, '0, "rd STATUS ev");
    xfer(1'b1, 8'h08, 32'h0000_0001, 32'h0, '0, "w1c bit0");
    chk1("int at w1c edge", wb_int_o, 1'b1);
    @(negedge clk);
    chk1("int fall", wb_int_o, 1'b0);
    xfer(1'b0, 8'h08, 32'h0, 32'h0000_0100, '0, "rd PEND w1c");

    // Coincident set and clear: set wins
    pulse_event(9'h001);
    @(negedge clk);
    chk1("int re-rise", wb_int_o, 1'b1);
    xfer(1'b1, 8'h08, 32'h0000_0001, 32'h0, 9'h001, "w1c+event");
    chk1("int set wins a", wb_int_o, 1'b1);
    @(negedge clk);
    chk1("int set wins b", wb_int_o, 1'b1);
    xfer(1'b0, 8'h08, 32'h0, 32'h0000_0101, '0, "rd PEND setwin");
    xfer(1'b0, 8'h10, 32'h0, 32'h0000_0001, '0, "rd STATUS setwin");

    // Held strobe: ack every other cycle
    @(negedge clk);
    chk1("burst idle", wb_ack_o, 1'b0);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 8'h04;
    repeat (3) sb.push_back(32'h0001_0000);
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk1($sformatf("burst ack c%0d", i), wb_ack_o, (i % 2) == 0);
      if (wb_ack_o) begin
        acks++;
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk($sformatf("burst rdata c%0d", i), wb_dat_o, e);
        end
      end else begin
        chk($sformatf("burst dat0 c%0d", i), wb_dat_o, 32'h0);
      end
    end
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    chk("burst ack count", 32'(acks), 32'd3);
    chk("burst sb empty", 32'(sb.size()), 32'd0);

    // Unmapped address
    xfer(1'b1, 8'h3C, 32'hDEAD_BEEF, 32'h0, '0, "wr unmapped");
    xfer(1'b0, 8'h3C, 32'h0, 32'h0,         '0, "rd unmapped");
    xfer(1'b0, 8'h00, 32'h0, 32'h0000_0004, '0, "rd CONFIG keep");
    xfer(1'b0, 8'h04, 32'h0, 32'h0001_0000, '0, "rd VERSION keep");
    xfer(1'b0, 8'h08, 32'h0, 32'h0000_0101, '0, "rd PEND keep");
    xfer(1'b0, 8'h0C, 32'h0, 32'h0000_0005, '0, "rd MASK keep");

    // Reset during a pending ack
    @(negedge clk);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 8'h00;
    @(negedge clk);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    chk1("pre-rst ack", wb_ack_o, 1'b1);
    chk1("pre-rst int", wb_int_o, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    chk_reset_outputs("mid rst");
    rst = 1'b0;
    xfer(1'b0, 8'h00, 32'h0, 32'h0000_0003, '0, "rd CONFIG post");
    xfer(1'b0, 8'h0C, 32'h0, 32'h0,         '0, "rd MASK post");
    xfer(1'b0, 8'h08, 32'h0, 32'h0,         '0, "rd PEND post");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
